phy_tx_arbiter: RTL

Transmit-side scheduler for the PCIe logical PHY. It shares the single lane-striping AXIS datapath between three packet sources: ordered sets, DLLPs and TLPs.
- Arbitration is at packet granularity. Once a source is granted, it owns the path until its tlast beat.
- A SKP interval timer forces ordered-set insertion at packet boundaries.
- A starvation counter guarantees TLP forward progress against DLLP traffic.

---
 rtl/pcie_phy_pkg.sv | 29 ++
 rtl/phy_tx_arbiter_if.sv | 32 +++
 rtl/skp_scheduler.sv | 43 ++++
 rtl/phy_tx_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pcie_phy_pkg.sv
// -----------------------------------------------------------------------------
// pcie_phy_pkg
//   Shared types and constants for the PCIe logical PHY transmit path.
//   - tx_arb_state_e : owner state of the TX arbiter
//   - SKP_INTERVAL_DEFAULT / SKP_CNT_WIDTH_DEFAULT : default SKP timer settings
//   - grant_of()     : one-hot {tlp,dllp,os} grant decoded from the state
// -----------------------------------------------------------------------------
package pcie_phy_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OS   = 2'd1,
        ST_DLLP = 2'd2,
        ST_TLP  = 2'd3
    } tx_arb_state_e;

    localparam int SKP_INTERVAL_DEFAULT  = 1180;
    localparam int SKP_CNT_WIDTH_DEFAULT = 12;

    function automatic logic [2:0] grant_of(input tx_arb_state_e state);
        case (state)
            ST_OS:   return 3'b001;
            ST_DLLP: return 3'b010;
            ST_TLP:  return 3'b100;
            default: return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/phy_tx_arbiter_if.sv
// -----------------------------------------------------------------------------
// phy_tx_arbiter_if
//   AXI-Stream bundle used for every source and for the output of the TX
//   arbiter.
//   Signals: tdata, tkeep, tvalid, tlast, tuser (source -> sink), tready
//   (sink -> source).
//   Modports: master (drives the beat), slave (receives the beat).
// -----------------------------------------------------------------------------
interface phy_tx_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int USER_WIDTH = 1
) ();

    logic [DATA_WIDTH-1:0] tdata;
    logic [KEEP_WIDTH-1:0] tkeep;
    logic                  tvalid;
    logic                  tlast;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tready;

    modport master (
        output tdata, tkeep, tvalid, tlast, tuser,
        input  tready
    );

    modport slave (
        input  tdata, tkeep, tvalid, tlast, tuser,
        output tready
    );

endinterface

// File: rtl/skp_scheduler.sv
// -----------------------------------------------------------------------------
// skp_scheduler
//   Counts link-up cycles and raises 'due' once SKP_INTERVAL cycles have
//   elapsed. The count then holds until an ordered set completes ('clear').
//   Ports:
//     clk_i, rst_ni : clock, asynchronous active-low reset
//     link_up       : timer runs only while high; low clears everything
//     clear         : last beat of an ordered set was accepted
//     due           : an SKP ordered set is owed
// -----------------------------------------------------------------------------
module skp_scheduler #(
    parameter int SKP_INTERVAL  = 1180,
    parameter int SKP_CNT_WIDTH = 12
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic link_up,
    input  logic clear,
    output logic due
);

    localparam logic [SKP_CNT_WIDTH-1:0] TERMINAL = SKP_CNT_WIDTH'(SKP_INTERVAL - 1);

    logic [SKP_CNT_WIDTH-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt <= '0;
            due <= 1'b0;
        end else if (!link_up || clear) begin
            // A clear coinciding with the terminal count restarts the interval.
            cnt <= '0;
            due <= 1'b0;
        end else if (cnt == TERMINAL) begin
            due <= 1'b1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/phy_tx_arbiter.sv
// -----------------------------------------------------------------------------
// phy_tx_arbiter
//   Packet-granular scheduler sharing the lane-striping AXIS path between the
//   ordered-set, DLLP and TLP sources. A granted source owns the path until
//   its tlast beat is accepted; one idle cycle separates packets.
//   Ports:
//     clk_i, rst_ni    : clock, asynchronous active-low reset
//     phy_link_up_i    : link up; low aborts the current packet and idles
//     s_os_axis        : ordered-set source (slave)
//     s_dllp_axis      : DLLP source (slave)
//     s_tlp_axis       : TLP source (slave)
//     m_axis           : output to lane striping (master)
//     skp_due_o        : SKP ordered set owed
//     grant_o          : one-hot owner {tlp,dllp,os}, 0 when idle
// -----------------------------------------------------------------------------
module phy_tx_arbiter
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int KEEP_WIDTH    = DATA_WIDTH / 8,
    parameter int USER_WIDTH    = 1,
    parameter int SKP_INTERVAL  = SKP_INTERVAL_DEFAULT,
    parameter int SKP_CNT_WIDTH = SKP_CNT_WIDTH_DEFAULT,
    parameter int STARVE_LIMIT  = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    phy_link_up_i,
    phy_tx_arbiter_if.slave         s_os_axis,
    phy_tx_arbiter_if.slave         s_dllp_axis,
    phy_tx_arbiter_if.slave         s_tlp_axis,
    phy_tx_arbiter_if.master        m_axis,
    output logic                    skp_due_o,
    output logic [2:0]              grant_o
);

    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    tx_arb_state_e         state_q;
    tx_arb_state_e         state_d;
    logic [STARVE_W-1:0]   starve_cnt;

    logic [DATA_WIDTH-1:0] mux_data;
    logic [KEEP_WIDTH-1:0] mux_keep;
    logic                  mux_valid;
    logic                  mux_last;
    logic [USER_WIDTH-1:0] mux_user;
    logic                  os_ready;
    logic                  dllp_ready;
    logic                  tlp_ready;
    logic                  last_hs;
    logic                  skp_clear;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        if (!phy_link_up_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (s_os_axis.tvalid) begin
                        state_d = ST_OS;
                    end else if (skp_due_o) begin
                        // Hold DLLP/TLP back until the owed SKP goes out.
                        state_d = ST_IDLE;
                    end else if ((starve_cnt >= STARVE_MAX) && s_tlp_axis.tvalid) begin
                        state_d = ST_TLP;
                    end else if (s_dllp_axis.tvalid) begin
                        state_d = ST_DLLP;
                    end else if (s_tlp_axis.tvalid) begin
                        state_d = ST_TLP;
                    end
                end
                default: begin
                    if (last_hs) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Output mux: owner's beat to m_axis, downstream ready back to the owner.
    // Link down gates valid/ready in the same cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        mux_data   = '0;
        mux_keep   = '0;
        mux_valid  = 1'b0;
        mux_last   = 1'b0;
        mux_user   = '0;
        os_ready   = 1'b0;
        dllp_ready = 1'b0;
        tlp_ready  = 1'b0;
        case (state_q)
            ST_OS: begin
                mux_data  = s_os_axis.tdata;
                mux_keep  = s_os_axis.tkeep;
                mux_valid = s_os_axis.tvalid && phy_link_up_i;
                mux_last  = s_os_axis.tlast;
                mux_user  = s_os_axis.tuser;
                os_ready  = m_axis.tready && phy_link_up_i;
            end
            ST_DLLP: begin
                mux_data   = s_dllp_axis.tdata;
                mux_keep   = s_dllp_axis.tkeep;
                mux_valid  = s_dllp_axis.tvalid && phy_link_up_i;
                mux_last   = s_dllp_axis.tlast;
                mux_user   = s_dllp_axis.tuser;
                dllp_ready = m_axis.tready && phy_link_up_i;
            end
            ST_TLP: begin
                mux_data  = s_tlp_axis.tdata;
                mux_keep  = s_tlp_axis.tkeep;
                mux_valid = s_tlp_axis.tvalid && phy_link_up_i;
                mux_last  = s_tlp_axis.tlast;
                mux_user  = s_tlp_axis.tuser;
                tlp_ready = m_axis.tready && phy_link_up_i;
            end
            default: ;
        endcase
    end

    assign last_hs   = mux_valid && m_axis.tready && mux_last;
    assign skp_clear = (state_q == ST_OS) && last_hs;

    assign m_axis.tdata       = mux_data;
    assign m_axis.tkeep       = mux_keep;
    assign m_axis.tvalid      = mux_valid;
    assign m_axis.tlast       = mux_last;
    assign m_axis.tuser       = mux_user;
    assign s_os_axis.tready   = os_ready;
    assign s_dllp_axis.tready = dllp_ready;
    assign s_tlp_axis.tready  = tlp_ready;
    assign grant_o            = grant_of(state_q);

    // -------------------------------------------------------------------------
    // Starvation counter: DLLP wins taken while a TLP waits.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt <= '0;
        end else if (!phy_link_up_i) begin
            starve_cnt <= '0;
        end else if (state_q == ST_IDLE) begin
            if (state_d == ST_DLLP && s_tlp_axis.tvalid && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end else if (state_d == ST_TLP) begin
                starve_cnt <= '0;
            end
        end
    end

    // -------------------------------------------------------------------------
    // SKP interval timer
    // -------------------------------------------------------------------------
    skp_scheduler #(
        .SKP_INTERVAL  (SKP_INTERVAL),
        .SKP_CNT_WIDTH (SKP_CNT_WIDTH)
    ) u_skp (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .link_up (phy_link_up_i),
        .clear   (skp_clear),
        .due     (skp_due_o)
    );

endmodule
